// File: rtl/game_pkg.sv
// Shared definitions for the game core: state and command encodings,
// datapath widths and the saturating score adder.
package game_pkg;

  localparam int unsigned TIMER_W = 7;
  localparam int unsigned SCORE_W = 10;
  localparam int unsigned STAGE_W = 2;
  localparam int unsigned LIVES_W = 2;

  typedef enum logic [2:0] {
    ST_READY       = 3'b001,
    ST_PLAYING     = 3'b010,
    ST_GAME_OVER   = 3'b011,
    ST_STAGE_CLEAR = 3'b100,
    ST_GAME_CLEAR  = 3'b101
  } game_state_e;

  typedef enum logic [3:0] {
    CMD_SCORE_INC    = 4'b0001,
    CMD_LIFE_DEC     = 4'b0010,
    CMD_TIMER_RESUME = 4'b0101,
    CMD_TO_READY     = 4'b1000,
    CMD_TO_PLAY      = 4'b1010,
    CMD_STAGE_CLEAR  = 4'b1100,
    CMD_GAME_OVER    = 4'b1101,
    CMD_GAME_CLEAR   = 4'b1110,
    CMD_RESET        = 4'b1111
  } cmd_e;

  // Score gains stage+1 points, clamped at smax.
  function automatic logic [SCORE_W-1:0] score_add(
    input logic [SCORE_W-1:0] s,
    input logic [STAGE_W-1:0] stg,
    input logic [SCORE_W-1:0] smax
  );
    logic [SCORE_W:0] sum;
    sum = {1'b0, s} + (SCORE_W+1)'(stg) + (SCORE_W+1)'(1);
    return (sum > {1'b0, smax}) ? smax : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second prescaler: counts clock cycles while enabled and flags the
// last cycle of each CLK_HZ-cycle period.
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   clr   - restart the period from zero (wins over en)
//   en    - count enable
//   tick  - high during the final cycle of a period (combinational)
module sec_prescaler #(
  parameter int unsigned CLK_HZ = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/game_state_core.sv
// Game state core: executes commands from the game FSM (4-bit flag qualified
// by a rising edge on trig) and owns state, stage, lives, score, high score
// and the seconds timer.
//   clk_1mhz           - system clock
//   rst_n              - asynchronous active-low reset
//   flag, trig         - command code and its strobe
//   done               - one-cycle pulse after a legal command executes
//   sec_posedge        - one-cycle pulse on each timer decrement
//   timer_running      - timer counting
//   timer              - seconds remaining
//   state              - game state encoding
//   stage, lives       - stage index and remaining lives
//   score, high_score  - current and best score
//   high_score_updated - last game end set a new high score
module game_state_core
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 1000000,
  parameter int unsigned READY_SECS  = 3,
  parameter int unsigned STAGE_SECS  = 30,
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned SCORE_MAX   = 999
) (
  input  logic               clk_1mhz,
  input  logic               rst_n,
  input  logic [3:0]         flag,
  input  logic               trig,
  output logic               done,
  output logic               sec_posedge,
  output logic               timer_running,
  output logic [TIMER_W-1:0] timer,
  output logic [2:0]         state,
  output logic [STAGE_W-1:0] stage,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic               high_score_updated
);

  game_state_e state_q;
  logic        trig_d;
  logic        tick;
  logic        cmd_edge;
  logic        cmd_legal;
  logic        timer_ctl;
  logic        cmd_exec;
  logic        presc_clr;

  assign state = state_q;

  // Legality depends on the current state; timer_ctl marks commands that
  // load or stop the timer, which also restart the prescaler.
  always_comb begin
    cmd_edge  = trig && !trig_d;
    cmd_legal = 1'b0;
    timer_ctl = 1'b0;
    case (flag)
      CMD_TIMER_RESUME: begin
        cmd_legal = (state_q == ST_READY) && !timer_running;
        timer_ctl = 1'b1;
      end
      CMD_TO_PLAY: begin
        cmd_legal = (state_q == ST_READY);
        timer_ctl = 1'b1;
      end
      CMD_SCORE_INC: cmd_legal = (state_q == ST_PLAYING) && (lives != '0);
      CMD_LIFE_DEC:  cmd_legal = (state_q == ST_PLAYING);
      CMD_STAGE_CLEAR, CMD_GAME_CLEAR, CMD_GAME_OVER: begin
        cmd_legal = (state_q == ST_PLAYING);
        timer_ctl = 1'b1;
      end
      CMD_TO_READY: begin
        cmd_legal = (state_q == ST_STAGE_CLEAR);
        timer_ctl = 1'b1;
      end
      CMD_RESET: begin
        cmd_legal = 1'b1;
        timer_ctl = 1'b1;
      end
      default: ;
    endcase
    cmd_exec  = cmd_edge && cmd_legal;
    presc_clr = cmd_exec && timer_ctl;
  end

  sec_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_prescaler (
    .clk  (clk_1mhz),
    .rst_n(rst_n),
    .clr  (presc_clr),
    .en   (timer_running),
    .tick (tick)
  );

  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= ST_READY;
      stage              <= '0;
      lives              <= LIVES_W'(START_LIVES);
      score              <= '0;
      high_score         <= '0;
      timer              <= TIMER_W'(READY_SECS);
      timer_running      <= 1'b0;
      done               <= 1'b0;
      sec_posedge        <= 1'b0;
      high_score_updated <= 1'b0;
      trig_d             <= 1'b0;
    end else begin
      trig_d      <= trig;
      done        <= cmd_exec;
      sec_posedge <= 1'b0;

      // A tick landing with a timer load/stop command is dropped; score and
      // life commands leave the tick alone.
      if (tick && !presc_clr) begin
        if (timer != '0) begin
          timer       <= timer - TIMER_W'(1);
          sec_posedge <= 1'b1;
        end else begin
          timer_running <= 1'b0;
        end
      end

      if (cmd_exec) begin
        case (flag)
          CMD_TIMER_RESUME: timer_running <= 1'b1;
          CMD_TO_PLAY: begin
            state_q       <= ST_PLAYING;
            timer         <= TIMER_W'(STAGE_SECS);
            timer_running <= 1'b1;
          end
          CMD_SCORE_INC: score <= score_add(score, stage, SCORE_W'(SCORE_MAX));
          CMD_LIFE_DEC:  lives <= (lives != '0) ? lives - LIVES_W'(1) : '0;
          CMD_STAGE_CLEAR: begin
            state_q       <= ST_STAGE_CLEAR;
            timer_running <= 1'b0;
          end
          CMD_GAME_CLEAR, CMD_GAME_OVER: begin
            state_q       <= (flag == CMD_GAME_CLEAR) ? ST_GAME_CLEAR : ST_GAME_OVER;
            timer_running <= 1'b0;
            if (score > high_score) begin
              high_score         <= score;
              high_score_updated <= 1'b1;
            end
          end
          CMD_TO_READY: begin
            stage         <= (stage != '1) ? stage + STAGE_W'(1) : stage;
            state_q       <= ST_READY;
            timer         <= TIMER_W'(READY_SECS);
            timer_running <= 1'b0;
          end
          CMD_RESET: begin
            state_q            <= ST_READY;
            stage              <= '0;
            lives              <= LIVES_W'(START_LIVES);
            score              <= '0;
            timer              <= TIMER_W'(READY_SECS);
            timer_running      <= 1'b0;
            high_score_updated <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
